// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes, register IDs,
// ALU modes and condition-code bit positions.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Pipeline status codes
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    // "No register" ID
    localparam logic [3:0] RNONE = 4'hF;

    // ALU modes (alu_64 function select)
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    // Condition-code bit positions within {ZF,SF,OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    // jXX / cmovXX condition function codes
    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;

endpackage

// File: rtl/alu_64.sv
// Y86-64 ALU: add, subtract (a-b), and, xor, with {ZF,SF,OF} flags.
module alu_64
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   mode,
    output logic [W-1:0] y,
    output logic [2:0]   cc
);

    logic of_flag;

    // Result and signed-overflow detection for the selected operation
    always_comb begin
        y       = '0;
        of_flag = 1'b0;
        case (mode)
            ALU_ADD: begin
                y       = a + b;
                of_flag = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                y       = a - b;
                of_flag = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
            end
            ALU_AND: y = a & b;
            default: y = a ^ b;
        endcase
        cc        = 3'b000;
        cc[CC_ZF] = (y == '0);
        cc[CC_SF] = y[W-1];
        cc[CC_OF] = of_flag;
    end

endmodule

// File: rtl/cond_eval.sv
// Evaluates a jXX/cmovXX condition code (ifun) against {ZF,SF,OF}.
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic [2:0] cc,
    output logic       cnd
);

    logic zf, sf, of_flag;

    assign zf      = cc[CC_ZF];
    assign sf      = cc[CC_SF];
    assign of_flag = cc[CC_OF];

    // Condition table; undefined function codes never fire
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = (sf ^ of_flag) | zf;
            C_L:      cnd = sf ^ of_flag;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~(sf ^ of_flag);
            C_G:      cnd = ~(sf ^ of_flag) & ~zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU operand/function selection,
// condition-code register, jXX/cmovXX evaluation and the M pipeline register.
module execute_stage
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   d_stat,
    input  logic [3:0]   d_icode,
    input  logic [3:0]   d_ifun,
    input  logic [W-1:0] d_valA,
    input  logic [W-1:0] d_valB,
    input  logic [W-1:0] d_valC,
    input  logic [3:0]   d_dstE,
    input  logic [3:0]   d_dstM,
    input  logic         E_stall,
    input  logic         E_bubble,
    input  logic         M_bubble,
    input  logic         m_stat_exc,
    input  logic         W_stat_exc,
    output logic         e_Cnd,
    output logic [3:0]   e_dstE,
    output logic [W-1:0] e_valE,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic [2:0]   cc_out
);

    localparam logic [W-1:0] STACK_STEP = W'(8);

    // E pipeline register
    logic [2:0]   e_stat_reg;
    logic [3:0]   e_icode_reg;
    logic [3:0]   e_ifun_reg;
    logic [W-1:0] e_vala_reg;
    logic [W-1:0] e_valb_reg;
    logic [W-1:0] e_valc_reg;
    logic [3:0]   e_dste_reg;
    logic [3:0]   e_dstm_reg;

    // M pipeline register and condition codes
    logic [2:0]   m_stat_reg;
    logic [3:0]   m_icode_reg;
    logic         m_cnd_reg;
    logic [W-1:0] m_vale_reg;
    logic [W-1:0] m_vala_reg;
    logic [3:0]   m_dste_reg;
    logic [3:0]   m_dstm_reg;
    logic [2:0]   cc_reg;

    // Datapath
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_mode;
    logic [W-1:0] alu_y;
    logic [2:0]   alu_cc;
    logic         raw_cnd;
    logic         cc_write;

    // E register: reset > bubble > stall > load from decode
    always_ff @(posedge clk) begin
        if (reset || E_bubble) begin
            e_stat_reg  <= S_AOK;
            e_icode_reg <= I_NOP;
            e_ifun_reg  <= 4'h0;
            e_vala_reg  <= '0;
            e_valb_reg  <= '0;
            e_valc_reg  <= '0;
            e_dste_reg  <= RNONE;
            e_dstm_reg  <= RNONE;
        end else if (!E_stall) begin
            e_stat_reg  <= d_stat;
            e_icode_reg <= d_icode;
            e_ifun_reg  <= d_ifun;
            e_vala_reg  <= d_valA;
            e_valb_reg  <= d_valB;
            e_valc_reg  <= d_valC;
            e_dste_reg  <= d_dstE;
            e_dstm_reg  <= d_dstM;
        end
    end

    // ALU operand and function selection; ALU computes aluB op aluA
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_mode = ALU_ADD;
        case (e_icode_reg)
            I_RRMOVQ, I_OPQ:              alu_a = e_vala_reg;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_valc_reg;
            I_CALL, I_PUSHQ:              alu_a = '0 - STACK_STEP;
            I_RET, I_POPQ:                alu_a = STACK_STEP;
            default:                      alu_a = '0;
        endcase
        case (e_icode_reg)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_RET, I_PUSHQ, I_POPQ:       alu_b = e_valb_reg;
            default:                      alu_b = '0;
        endcase
        if (e_icode_reg == I_OPQ) begin
            alu_mode = e_ifun_reg[1:0];
        end
    end

    alu_64 #(.W(W)) u_alu (
        .a    (alu_b),
        .b    (alu_a),
        .mode (alu_mode),
        .y    (alu_y),
        .cc   (alu_cc)
    );

    cond_eval u_cond (
        .ifun (e_ifun_reg),
        .cc   (cc_reg),
        .cnd  (raw_cnd)
    );

    // Condition only meaningful for cmovXX and jXX; a failed cmov drops its write
    assign e_Cnd    = ((e_icode_reg == I_RRMOVQ) || (e_icode_reg == I_JXX)) && raw_cnd;
    assign e_dstE   = ((e_icode_reg == I_RRMOVQ) && !e_Cnd) ? RNONE : e_dste_reg;
    assign e_valE   = alu_y;
    assign cc_write = (e_icode_reg == I_OPQ) && !m_stat_exc && !W_stat_exc;

    // CC register and M register: reset > bubble > load from execute
    always_ff @(posedge clk) begin
        if (reset) begin
            cc_reg <= 3'b100;
        end else if (cc_write) begin
            cc_reg <= alu_cc;
        end
        if (reset || M_bubble) begin
            m_stat_reg  <= S_AOK;
            m_icode_reg <= I_NOP;
            m_cnd_reg   <= 1'b0;
            m_vale_reg  <= '0;
            m_vala_reg  <= '0;
            m_dste_reg  <= RNONE;
            m_dstm_reg  <= RNONE;
        end else begin
            m_stat_reg  <= e_stat_reg;
            m_icode_reg <= e_icode_reg;
            m_cnd_reg   <= e_Cnd;
            m_vale_reg  <= alu_y;
            m_vala_reg  <= e_vala_reg;
            m_dste_reg  <= e_dstE;
            m_dstm_reg  <= e_dstm_reg;
        end
    end

    assign M_stat  = m_stat_reg;
    assign M_icode = m_icode_reg;
    assign M_Cnd   = m_cnd_reg;
    assign M_valE  = m_vale_reg;
    assign M_valA  = m_vala_reg;
    assign M_dstE  = m_dste_reg;
    assign M_dstM  = m_dstm_reg;
    assign cc_out  = cc_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage with hand-computed expected values.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  d_stat;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    logic [63:0] d_valC;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic        E_stall;
    logic        E_bubble;
    logic        M_bubble;
    logic        m_stat_exc;
    logic        W_stat_exc;
    logic        e_Cnd;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [2:0]  cc_out;

    int tests_run = 0;
    int errors    = 0;

    execute_stage #(.W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_stat     (d_stat),
        .d_icode    (d_icode),
        .d_ifun     (d_ifun),
        .d_valA     (d_valA),
        .d_valB     (d_valB),
        .d_valC     (d_valC),
        .d_dstE     (d_dstE),
        .d_dstM     (d_dstM),
        .E_stall    (E_stall),
        .E_bubble   (E_bubble),
        .M_bubble   (M_bubble),
        .m_stat_exc (m_stat_exc),
        .W_stat_exc (W_stat_exc),
        .e_Cnd      (e_Cnd),
        .e_dstE     (e_dstE),
        .e_valE     (e_valE),
        .M_stat     (M_stat),
        .M_icode    (M_icode),
        .M_Cnd      (M_Cnd),
        .M_valE     (M_valE),
        .M_valA     (M_valA),
        .M_dstE     (M_dstE),
        .M_dstM     (M_dstM),
        .cc_out     (cc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one decoded instruction and clock it into the E register
    task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] vc, input logic [3:0] de,
                         input logic [3:0] dm);
        d_stat  = 3'd1;
        d_icode = ic;
        d_ifun  = fn;
        d_valA  = va;
        d_valB  = vb;
        d_valC  = vc;
        d_dstE  = de;
        d_dstM  = dm;
        tick();
        $display("[TB] issue icode=%h ifun=%h valA=%0h valB=%0h valC=%0h -> M_icode=%h M_valE=%0h cc=%b",
                 ic, fn, va, vb, vc, M_icode, M_valE, cc_out);
    endtask

    initial begin
        reset = 1'b1;
        d_stat = 3'd1; d_icode = 4'h1; d_ifun = 4'h0;
        d_valA = '0; d_valB = '0; d_valC = '0;
        d_dstE = 4'hF; d_dstM = 4'hF;
        E_stall = 1'b0; E_bubble = 1'b0; M_bubble = 1'b0;
        m_stat_exc = 1'b0; W_stat_exc = 1'b0;

        // Reset state
        tick();
        check("rst_M_stat",  M_stat, 1);
        check("rst_M_icode", M_icode, 1);
        check("rst_M_Cnd",   M_Cnd, 0);
        check("rst_M_valE",  M_valE, 0);
        check("rst_M_dstE",  M_dstE, 4'hF);
        check("rst_M_dstM",  M_dstM, 4'hF);
        check("rst_cc",      cc_out, 3'b100);
        check("rst_e_dstE",  e_dstE, 4'hF);
        reset = 1'b0;

        // 1. addq 54+46, then subq 10-10
        issue(4'h6, 4'h0, 64'd54, 64'd46, 64'd0, 4'h3, 4'hF);
        check("add_e_valE", e_valE, 100);
        issue(4'h6, 4'h1, 64'd10, 64'd10, 64'd0, 4'h4, 4'hF);
        check("add_M_valE", M_valE, 100);
        check("add_M_dstE", M_dstE, 4'h3);
        check("add_cc",     cc_out, 3'b000);
        issue(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        check("sub_M_valE", M_valE, 0);
        check("sub_cc",     cc_out, 3'b100);

        // 2. signed overflow, then irmovq leaves CC alone
        issue(4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0, 4'h3, 4'hF);
        issue(4'h3, 4'h0, 64'd0, 64'd0, 64'd5, 4'h2, 4'hF);
        check("ovf_M_valE", M_valE, 64'h8000_0000_0000_0000);
        check("ovf_cc",     cc_out, 3'b011);
        issue(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        check("irmov_M_valE", M_valE, 5);
        check("irmov_cc",     cc_out, 3'b011);

        // 3. cmovle taken with CC=010, not taken with CC=000
        issue(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 4'h3, 4'hF);
        issue(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        check("neg_cc", cc_out, 3'b010);
        issue(4'h2, 4'h1, 64'd7, 64'd0, 64'd0, 4'h5, 4'hF);
        check("cmovle_t_Cnd",  e_Cnd, 1);
        check("cmovle_t_dstE", e_dstE, 4'h5);
        check("cmovle_t_valE", e_valE, 7);
        issue(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h3, 4'hF);
        check("cmovle_t_M_Cnd",  M_Cnd, 1);
        check("cmovle_t_M_dstE", M_dstE, 4'h5);
        issue(4'h2, 4'h1, 64'd7, 64'd0, 64'd0, 4'h5, 4'hF);
        check("pos_cc",        cc_out, 3'b000);
        check("cmovle_n_Cnd",  e_Cnd, 0);
        check("cmovle_n_dstE", e_dstE, 4'hF);

        // 4. stack pointer and address arithmetic
        issue(4'hA, 4'h0, 64'd9, 64'h100, 64'd0, 4'h4, 4'hF);
        check("push_e_valE", e_valE, 64'hF8);
        issue(4'h9 + 4'h2, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'h3);
        check("pop_e_valE",  e_valE, 64'h108);
        check("push_M_valE", M_valE, 64'hF8);
        issue(4'h5, 4'h0, 64'd0, 64'h20, 64'd16, 4'hF, 4'h1);
        check("mrmov_e_valE", e_valE, 64'h30);
        check("pop_M_valE",   M_valE, 64'h108);
        issue(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        check("mrmov_M_valE", M_valE, 64'h30);
        check("mrmov_M_dstM", M_dstM, 4'h1);
        check("jxx_cc_hold",  cc_out, 3'b000);

        // 5. exceptions downstream block CC writes
        issue(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, 4'hF);
        m_stat_exc = 1'b1;
        issue(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        m_stat_exc = 1'b0;
        check("mexc_cc",     cc_out, 3'b000);
        check("mexc_M_valE", M_valE, 0);
        check("mexc_M_icode", M_icode, 6);
        issue(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, 4'hF);
        W_stat_exc = 1'b1;
        issue(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        W_stat_exc = 1'b0;
        check("wexc_cc", cc_out, 3'b000);

        // Bubble beats stall; bubble leaves CC alone
        E_bubble = 1'b1; E_stall = 1'b1;
        issue(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h6, 4'hF);
        E_bubble = 1'b0; E_stall = 1'b0;
        check("bub_e_dstE", e_dstE, 4'hF);
        issue(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        check("bub_M_icode", M_icode, 1);
        check("bub_M_dstE",  M_dstE, 4'hF);
        check("bub_cc",      cc_out, 3'b000);

        // M bubble discards the executing instruction at M
        issue(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 4'h6, 4'hF);
        M_bubble = 1'b1;
        issue(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        M_bubble = 1'b0;
        check("mbub_M_icode", M_icode, 1);
        check("mbub_M_valE",  M_valE, 0);

        // 6. E stall for three cycles repeats the held instruction into M
        issue(4'h3, 4'h0, 64'd0, 64'd0, 64'h55, 4'h3, 4'hF);
        E_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF);
            check("stall_M_icode", M_icode, 3);
            check("stall_M_valE",  M_valE, 64'h55);
        end
        E_stall = 1'b0;

        // Reset mid-stream discards in-flight work and reinitialises CC
        issue(4'h6, 4'h1, 64'd2, 64'd1, 64'd0, 4'h3, 4'hF);
        reset = 1'b1;
        issue(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h3, 4'hF);
        reset = 1'b0;
        check("mrst_M_icode", M_icode, 1);
        check("mrst_cc",      cc_out, 3'b100);
        check("mrst_M_valE",  M_valE, 0);
        check("mrst_e_valE",  e_valE, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, errors);
        $finish;
    end

endmodule
